// File: rtl/piso_serializer.sv
// Parallel-in serial-out serializer with ready/valid load and back-to-back frames.
// Define PISO_PARITY_EN to append an even-parity bit after the data bits.
module piso_serializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             direction,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] din,
    output logic             load_ready,
    output logic             dout,
    output logic             dout_valid,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

`ifdef PISO_PARITY_EN
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;
`else
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;
`endif

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               dir_q, dir_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
`ifdef PISO_PARITY_EN
    logic               parity_q, parity_d;
`endif

    logic last_data;
    logic frame_last;
    logic accept;

    assign last_data = (state_q == SHIFT) && (cnt_q == CNT_LAST);
`ifdef PISO_PARITY_EN
    assign frame_last = (state_q == PARITY);
`else
    assign frame_last = last_data;
`endif

    // Ready also on the final frame bit so a new word can follow without a gap.
    assign load_ready = (state_q == IDLE) || frame_last;
    assign accept     = load_valid && load_ready;
    assign busy       = (state_q != IDLE);
    assign dout_valid = busy;
    assign done       = frame_last;

    always_comb begin
        dout = 1'b0;
        case (state_q)
            SHIFT:   dout = dir_q ? shift_q[WIDTH-1] : shift_q[0];
`ifdef PISO_PARITY_EN
            PARITY:  dout = parity_q;
`endif
            default: dout = 1'b0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        dir_d    = dir_q;
        cnt_d    = cnt_q;
`ifdef PISO_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            SHIFT: begin
                if (!last_data) begin
                    shift_d = dir_q ? {shift_q[WIDTH-2:0], 1'b0}
                                    : {1'b0, shift_q[WIDTH-1:1]};
                    cnt_d   = cnt_q + CNT_W'(1);
                end else begin
`ifdef PISO_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = IDLE;
                    shift_d = '0;
                    cnt_d   = '0;
`endif
                end
            end
`ifdef PISO_PARITY_EN
            PARITY: begin
                state_d = IDLE;
                shift_d = '0;
                cnt_d   = '0;
            end
`endif
            default: ;
        endcase

        // A load always wins: it either starts from IDLE or chains onto the last bit.
        if (accept) begin
            state_d  = SHIFT;
            shift_d  = din;
            dir_d    = direction;
            cnt_d    = '0;
`ifdef PISO_PARITY_EN
            parity_d = ^din;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            shift_q  <= '0;
            dir_q    <= 1'b0;
            cnt_q    <= '0;
`ifdef PISO_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            dir_q    <= dir_d;
            cnt_q    <= cnt_d;
`ifdef PISO_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Scoreboard bench for piso_serializer: frame bits are predicted at load time and
// checked by an independent monitor whenever dout_valid is high.
module tb_piso_serializer;

    localparam int W = 4;
`ifdef PISO_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         direction;
    logic         load_valid;
    logic [W-1:0] din;
    logic         load_ready;
    logic         dout;
    logic         dout_valid;
    logic         busy;
    logic         done;

    always #5 clk = ~clk;

    piso_serializer #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .direction  (direction),
        .load_valid (load_valid),
        .din        (din),
        .load_ready (load_ready),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy),
        .done       (done)
    );

    typedef struct {
        logic b;
        logic last;
    } exp_t;

    exp_t exp_q[$];
    int   compared   = 0;
    int   mismatched = 0;
    int   remaining  = 0;  // frame bits still to be shown, including the current one

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference: the frame is the word read in the chosen order, then optional parity.
    task automatic push_frame(input logic [W-1:0] d, input logic dr);
        int   ones;
        exp_t e;
        ones = 0;
        for (int i = 0; i < W; i++) begin
            e.b    = dr ? d[W-1-i] : d[i];
            e.last = (i == FL - 1);
            if (d[i]) ones++;
            exp_q.push_back(e);
        end
`ifdef PISO_PARITY_EN
        e.b    = logic'(ones % 2);
        e.last = 1'b1;
        exp_q.push_back(e);
`endif
    endtask

    // One clock: called at a negedge, returns at the next negedge.
    task automatic cycle(input logic lv, input logic [W-1:0] d, input logic dr);
        logic acc;
        check("load_ready", 32'(load_ready), 32'(remaining <= 1));
        check("busy",       32'(busy),       32'(remaining > 0));
        check("dout_valid", 32'(dout_valid), 32'(remaining > 0));
        load_valid = lv;
        din        = d;
        direction  = dr;
        acc        = lv && (remaining <= 1);
        @(posedge clk);
        if (remaining > 0) remaining--;
        if (acc) begin
            push_frame(d, dr);
            remaining = FL;
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b0, W'($urandom), 1'($urandom));
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (dout_valid) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_bit", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("dout", 32'(dout), 32'(e.b));
                    check("done", 32'(done), 32'(e.last));
                end
            end else begin
                check("idle_dout", 32'(dout), 32'd0);
                check("idle_done", 32'(done), 32'd0);
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout"},       32'(dout),       32'd0);
        check({tag, "_dout_valid"}, 32'(dout_valid), 32'd0);
        check({tag, "_busy"},       32'(busy),       32'd0);
        check({tag, "_done"},       32'(done),       32'd0);
        check({tag, "_load_ready"}, 32'(load_ready), 32'd1);
    endtask

    initial begin
        rst        = 1'b1;
        load_valid = 1'b0;
        din        = '0;
        direction  = 1'b0;
        #1;
        check_reset_outputs("reset");
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);

        // MSB first single word, then idle
        cycle(1'b1, 4'b1011, 1'b1);
        idle(FL + 2);

        // LSB first with direction toggling mid-frame
        cycle(1'b1, 4'b1011, 1'b0);
        for (int i = 0; i < FL + 2; i++)
            cycle(1'b0, 4'b0000, 1'(i % 2 == 0));

        // Back-to-back A then 5 with load_valid held
        cycle(1'b1, 4'hA, 1'b1);
        for (int i = 0; i < FL; i++)
            cycle(1'b1, 4'h5, 1'b1);
        idle(FL + 2);

        // Load attempt while busy must be ignored
        cycle(1'b1, 4'hF, 1'b1);
        cycle(1'b1, 4'h0, 1'b0);
        idle(FL + 2);

        // Parity zero case
        cycle(1'b1, 4'b1001, 1'b1);
        idle(FL + 1);

        // Asynchronous reset after the second bit of F
        cycle(1'b1, 4'hF, 1'b1);
        cycle(1'b0, 4'h0, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midreset");
        exp_q.delete();
        remaining = 0;
        @(posedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        cycle(1'b1, 4'h3, 1'b1);
        idle(FL + 2);

        // Randomized traffic
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom));
        idle(FL + 2);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
PISO_SERIALIZER -- requirements
Module: piso_serializer

Interface
REQ-001 Parameter: WIDTH, default 4, parallel word width in bits (legal range 2..16).
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: direction  input  1  bit order; 1 = MSB first, 0 = LSB first; sampled only at load.
REQ-005 Port: load_valid  input  1  parallel word on din is available.
REQ-006 Port: din  input  WIDTH  parallel word to serialize.
REQ-007 Port: load_ready  output  1  block accepts a word this cycle.
REQ-008 Port: dout  output  1  serial data bit feeding the downstream shift register.
REQ-009 Port: dout_valid  output  1  dout carries a frame bit this cycle.
REQ-010 Port: busy  output  1  frame in progress (state != IDLE).
REQ-011 Port: done  output  1  one-cycle pulse marking the final bit of a frame.

Function
REQ-012 FSM states: IDLE, SHIFT, PARITY (PARITY exists only with PISO_PARITY_EN).
REQ-013 Load handshake: word accepted on a rising edge where load_valid && load_ready; din and direction captured into internal shift and direction registers.
REQ-014 load_ready = 1 in IDLE, and also during the cycle the final frame bit is on dout (back-to-back support); 0 otherwise.
REQ-015 Latency: first bit on dout, with dout_valid = 1, in the cycle immediately after acceptance.
REQ-016 SHIFT: presents WIDTH data bits on consecutive cycles, one per cycle; bit counter counts 0..WIDTH-1.
REQ-017 Order: direction=1 -> din[WIDTH-1] first down to din[0]; direction=0 -> din[0] first up to din[WIDTH-1].
REQ-018 Direction or din changes after acceptance have no effect on the current frame.
REQ-019 load_valid while load_ready = 0 is ignored; no word captured, no state change.
REQ-020 End of frame, no new load: SHIFT (or PARITY) -> IDLE; dout_valid = 0 in the following cycle.
REQ-021 End of frame with load accepted: next frame's first bit in the following cycle; dout_valid stays 1 with no gap.
REQ-022 done = 1 exactly in the cycle the last frame bit (final data bit, or parity bit when enabled) is on dout.
REQ-023 dout = 0 whenever dout_valid = 0.
REQ-024 busy = 1 in SHIFT and PARITY, 0 in IDLE.

Reset
REQ-025 rst asserted at any time, including mid-frame: state -> IDLE, bit counter -> 0, shift register -> 0, direction register -> 0, without waiting for clk.
REQ-026 During and after reset: dout = 0, dout_valid = 0, busy = 0, done = 0, load_ready = 1; a partial frame is discarded, never resumed.

Configuration
REQ-027 Macro PISO_PARITY_EN defined: after the WIDTH data bits, one PARITY cycle drives the even-parity bit (XOR of all WIDTH bits) with dout_valid = 1; frame length WIDTH+1 cycles.
REQ-028 Macro PISO_PARITY_EN undefined: no PARITY state or logic; frame length exactly WIDTH cycles.

Verification
REQ-029 WIDTH=4, direction=1, din=4'b1011 loaded once -> dout 1,0,1,1 on 4 consecutive cycles starting 1 cycle after load, done on the 4th, dout_valid=0 after.
REQ-030 direction=0, din=4'b1011 -> dout 1,1,0,1; direction toggled mid-frame -> sequence unchanged.
REQ-031 Back-to-back: 4'hA then 4'h5, MSB first, load_valid held -> dout 1,0,1,0,0,1,0,1 with dout_valid high for 8 continuous cycles, done on cycles 4 and 8.
REQ-032 rst pulsed after 2nd bit of 4'hF -> dout=0, dout_valid=0, busy=0 immediately; next load 4'h3 (MSB first) -> 0,0,1,1 cleanly.
REQ-033 load_valid pulsed with din=4'h0 during a 4'hF frame -> ignored; output stays 1,1,1,1.
REQ-034 With PISO_PARITY_EN, din=4'b1011 MSB first -> dout 1,0,1,1,1 over 5 cycles, done on the 5th; din=4'b1001 -> parity bit 0.
